// File: rtl/pdm_deserializer_mc.sv
// rtl/pdm_deserializer_mc.sv - multi-channel PDM clock generator, deserializer and word handshake
// Build option PDM_DENSITY_OUT_EN: each word carries the per-period count of 1s instead of raw bits.
module pdm_deserializer_mc #(
    parameter int WORD_W  = 16,
    parameter int CLK_DIV = 100,
    parameter int NUM_CH  = 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     data_in,
    output logic                     pdm_clk_o,
    output logic                     pdm_lrsel_o,
    output logic [NUM_CH*WORD_W-1:0] data_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     overrun_o,
    input  logic                     clear_overrun_i
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int OW = NUM_CH * WORD_W;

    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;
    logic          hi_evt;
    logic          lo_evt;
    logic          word_done;
    logic [OW-1:0] word_next;

    assign pdm_lrsel_o = 1'b0;

    assign hi_evt    = enable && (div_cnt == DW'(CLK_DIV / 2 - 1));
    assign lo_evt    = enable && (div_cnt == DW'(CLK_DIV - 1));
    assign word_done = lo_evt && (bit_cnt == BW'(WORD_W - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            pdm_clk_o <= 1'b0;
        end else if (!enable) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            pdm_clk_o <= 1'b0;
        end else begin
            pdm_clk_o <= (div_cnt < DW'(CLK_DIV / 2));
            div_cnt   <= lo_evt ? '0 : div_cnt + DW'(1);
            if (lo_evt) begin
                bit_cnt <= word_done ? '0 : bit_cnt + BW'(1);
            end
        end
    end

    // ch0 samples at the end of the high phase, ch1 at the end of the low phase
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic take;
        assign take = (c == 0) ? hi_evt : lo_evt;
`ifdef PDM_DENSITY_OUT_EN
        localparam int CW = $clog2(WORD_W + 1);
        logic [CW-1:0] acc;
        logic [CW-1:0] acc_next;
        assign acc_next = acc + CW'(data_in);
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                acc <= '0;
            end else if (!enable || word_done) begin
                acc <= '0;
            end else if (take) begin
                acc <= acc_next;
            end
        end
        // ch1's final bit lands on the completion edge, so it is folded in combinationally
        assign word_next[c*WORD_W +: WORD_W] = WORD_W'((c == 0) ? acc : acc_next);
`else
        logic [WORD_W-1:0] sh;
        logic [WORD_W-1:0] sh_next;
        assign sh_next = {sh[WORD_W-2:0], data_in};
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                sh <= '0;
            end else if (!enable) begin
                sh <= '0;
            end else if (take) begin
                sh <= sh_next;
            end
        end
        assign word_next[c*WORD_W +: WORD_W] = (c == 0) ? sh : sh_next;
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_o    <= '0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            if (word_done && (!valid_o || ready_i)) begin
                data_o  <= word_next;
                valid_o <= 1'b1;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
            if (word_done && valid_o && !ready_i) begin
                overrun_o <= 1'b1;
            end else if (clear_overrun_i) begin
                overrun_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pdm_deserializer_mc.sv
// tb/tb_pdm_deserializer_mc.sv - self-checking bench for mono and stereo pdm_deserializer_mc
module tb_pdm_deserializer_mc;

    localparam int W   = 16;
    localparam int DIV = 4;
`ifdef PDM_DENSITY_OUT_EN
    localparam bit DENS = 1'b1;
`else
    localparam bit DENS = 1'b0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_n, enable, data_in, ready_i, clear_overrun_i;
    logic m_pdm_clk, m_lrsel, m_valid, m_overrun;
    logic [W-1:0] m_data;
    logic s_pdm_clk, s_lrsel, s_valid, s_overrun;
    logic [2*W-1:0] s_data;

    int n_checks = 0;
    int n_err    = 0;
    bit q0[$];
    bit q1[$];

    typedef struct {
        logic [15:0] ch0;
        logic [15:0] ch1;
        logic [15:0] raw_m;
        logic [31:0] raw_s;
        logic [15:0] den_m;
        logic [31:0] den_s;
    } vec_t;
    vec_t vecs[4];

    logic [15:0] ra, rb, e0, e1;
    int cnt_v, cnt_c;

    pdm_deserializer_mc #(.WORD_W(W), .CLK_DIV(DIV), .NUM_CH(1)) u_mono (
        .clock(clock), .reset_n(reset_n), .enable(enable), .data_in(data_in),
        .pdm_clk_o(m_pdm_clk), .pdm_lrsel_o(m_lrsel), .data_o(m_data),
        .valid_o(m_valid), .ready_i(ready_i), .overrun_o(m_overrun),
        .clear_overrun_i(clear_overrun_i)
    );

    pdm_deserializer_mc #(.WORD_W(W), .CLK_DIV(DIV), .NUM_CH(2)) u_st (
        .clock(clock), .reset_n(reset_n), .enable(enable), .data_in(data_in),
        .pdm_clk_o(s_pdm_clk), .pdm_lrsel_o(s_lrsel), .data_o(s_data),
        .valid_o(s_valid), .ready_i(ready_i), .overrun_o(s_overrun),
        .clear_overrun_i(clear_overrun_i)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic realign();
        enable = 1'b0;
        tick();
        tick();
        enable = 1'b1;
    endtask

    // Reference: a word is the first W bits received on a channel, MSB first, or their ones-count
    function automatic logic [15:0] pop_word(input int ch);
        int val  = 0;
        int ones = 0;
        bit b;
        for (int i = 0; i < W; i++) begin
            if (ch == 0) b = q0.pop_front();
            else         b = q1.pop_front();
            val  = val * 2 + int'(b);
            ones = ones + int'(b);
        end
        return DENS ? 16'(ones) : 16'(val);
    endfunction

    task automatic run_word(input logic [15:0] c0, input logic [15:0] c1, input bit chk);
        int bad_v   = 0;
        int bad_clk = 0;
        for (int i = 0; i < W; i++) begin
            q0.push_back(c0[W-1-i]);
            q1.push_back(c1[W-1-i]);
            for (int k = 0; k < DIV; k++) begin
                data_in = (k < DIV / 2) ? c0[W-1-i] : c1[W-1-i];
                tick();
                if ((m_pdm_clk !== (k < DIV / 2)) || (s_pdm_clk !== (k < DIV / 2))) bad_clk++;
                if (chk && ((m_valid !== (i * DIV + k == W * DIV - 1)) ||
                            (s_valid !== (i * DIV + k == W * DIV - 1)))) bad_v++;
            end
        end
        check("pdm_clk_pattern", 64'(bad_clk), 64'd0);
        if (chk) check("valid_timing", 64'(bad_v), 64'd0);
    endtask

    initial begin
        vecs[0] = '{16'hA5C3, 16'h0000, 16'hA5C3, 32'h0000_A5C3, 16'd8,  {16'd0,  16'd8}};
        vecs[1] = '{16'hFFFF, 16'hAAAA, 16'hFFFF, 32'hAAAA_FFFF, 16'd16, {16'd8,  16'd16}};
        vecs[2] = '{16'h0000, 16'hFFFF, 16'h0000, 32'hFFFF_0000, 16'd0,  {16'd16, 16'd0}};
        vecs[3] = '{16'h1234, 16'h8001, 16'h1234, 32'h8001_1234, 16'd5,  {16'd2,  16'd5}};

        reset_n = 1'b0; enable = 1'b0; data_in = 1'b0; ready_i = 1'b1; clear_overrun_i = 1'b0;
        repeat (3) tick();
        check("rst_valid",   {m_valid, s_valid}, 2'b00);
        check("rst_data",    {m_data, s_data}, 48'd0);
        check("rst_overrun", {m_overrun, s_overrun}, 2'b00);
        check("rst_clk",     {m_pdm_clk, s_pdm_clk, m_lrsel, s_lrsel}, 4'b0000);
        reset_n = 1'b1;
        tick();

        // Table: back-to-back words with ready held high
        enable = 1'b1;
        for (int v = 0; v < 4; v++) begin
            run_word(vecs[v].ch0, vecs[v].ch1, 1'b1);
            void'(pop_word(0));
            void'(pop_word(1));
            check("tbl_mono",   m_data, DENS ? vecs[v].den_m : vecs[v].raw_m);
            check("tbl_stereo", s_data, DENS ? vecs[v].den_s : vecs[v].raw_s);
        end

        // Random words against the queue model
        for (int r = 0; r < 6; r++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_word(ra, rb, 1'b1);
            e0 = pop_word(0);
            e1 = pop_word(1);
            check("rand_mono",   m_data, e0);
            check("rand_stereo", s_data, {e1, e0});
        end
        check("rand_no_overrun", {m_overrun, s_overrun}, 2'b00);

        // Backpressure across two completions
        realign();
        ready_i = 1'b0;
        run_word(16'hBEEF, 16'h0F0F, 1'b0);
        run_word(16'h1357, 16'hF00D, 1'b0);
        e0 = pop_word(0);
        e1 = pop_word(1);
        void'(pop_word(0));
        void'(pop_word(1));
        check("bp_valid",   {m_valid, s_valid}, 2'b11);
        check("bp_hold_m",  m_data, e0);
        check("bp_hold_s",  s_data, {e1, e0});
        check("bp_overrun", {m_overrun, s_overrun}, 2'b11);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check("bp_consumed",      {m_valid, s_valid}, 2'b00);
        check("bp_overrun_stays", {m_overrun, s_overrun}, 2'b11);
        check("bp_data_kept",     m_data, e0);
        clear_overrun_i = 1'b1;
        tick();
        clear_overrun_i = 1'b0;
        check("bp_overrun_clr", {m_overrun, s_overrun}, 2'b00);

        // Mid-word disable after 7 bits, then a fresh aligned word
        ready_i = 1'b1;
        realign();
        for (int t = 0; t < 7 * DIV; t++) begin
            data_in = 1'($urandom);
            tick();
        end
        enable = 1'b0;
        tick();
        check("dis_clk_low", {m_pdm_clk, s_pdm_clk}, 2'b00);
        cnt_v = 0;
        cnt_c = 0;
        for (int t = 0; t < 80; t++) begin
            data_in = 1'($urandom);
            tick();
            if (m_valid || s_valid) cnt_v++;
            if (m_pdm_clk || s_pdm_clk) cnt_c++;
        end
        check("dis_no_valid", 64'(cnt_v), 64'd0);
        check("dis_clk_idle", 64'(cnt_c), 64'd0);
        enable = 1'b1;
        run_word(16'h1234, 16'h5678, 1'b1);
        e0 = pop_word(0);
        e1 = pop_word(1);
        check("reen_mono",   m_data, e0);
        check("reen_stereo", s_data, {e1, e0});

        // Asynchronous reset in the middle of a word with state populated
        ready_i = 1'b0;
        realign();
        run_word(16'hC0DE, 16'h7E57, 1'b0);
        run_word(16'h0001, 16'h8000, 1'b0);
        void'(pop_word(0)); void'(pop_word(1));
        void'(pop_word(0)); void'(pop_word(1));
        data_in = 1'b1;
        repeat (9) tick();
        check("pre_rst_state", {m_valid, m_overrun, m_pdm_clk}, 3'b111);
        reset_n = 1'b0;
        #2;
        check("arst_valid",   {m_valid, s_valid}, 2'b00);
        check("arst_data",    {m_data, s_data}, 48'd0);
        check("arst_overrun", {m_overrun, s_overrun}, 2'b00);
        check("arst_clk",     {m_pdm_clk, s_pdm_clk}, 2'b00);
        enable = 1'b0;
        tick();
        reset_n = 1'b1;
        cnt_c = 0;
        for (int t = 0; t < 8; t++) begin
            tick();
            if (m_pdm_clk || s_pdm_clk || m_valid || s_valid) cnt_c++;
        end
        check("post_rst_idle", 64'(cnt_c), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
